// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit burst scheduler.
package uart_tx_sched_pkg;

  localparam int unsigned FifoDepth  = 16;
  localparam int unsigned DataWidth  = 8;
  localparam int unsigned LevelWidth = $clog2(FifoDepth + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StFetch,
    StCapture,
    StLoad,
    StWaitAck,
    StWaitDone,
    StGap
  } state_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// FIFO and UART side signals of the scheduler; master is the scheduler itself.
interface uart_tx_sched_if;
  import uart_tx_sched_pkg::*;

  logic [LevelWidth-1:0] fifo_level;
  logic                  fifo_tx_status;
  logic [DataWidth-1:0]  fifo_data;
  logic                  uart_busy;
  logic                  start_tx;
  logic                  next_frame;
  logic [DataWidth-1:0]  uart_data;
  logic                  uart_load;

  modport master (
    input  fifo_level, fifo_tx_status, fifo_data, uart_busy,
    output start_tx, next_frame, uart_data, uart_load
  );

  modport slave (
    output fifo_level, fifo_tx_status, fifo_data, uart_busy,
    input  start_tx, next_frame, uart_data, uart_load
  );

endinterface

// File: rtl/tx_idle_timer.sv
// Saturating idle timer: counts while run is high, clears as soon as run drops.
module tx_idle_timer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = '0;
    if (run) begin
      count_d = (count_q == CntMax) ? count_q : count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Gated by run so an empty FIFO can never look like an expired wait.
  assign expired = run && (count_q == CntMax);

endmodule

// File: rtl/uart_tx_sched.sv
// Drains the TX FIFO into the UART in bursts triggered by level, flush or idle timeout.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned BATCH_THRESHOLD = 16,
  parameter int unsigned IDLE_TIMEOUT    = 1000,
  parameter int unsigned FRAME_GAP       = 2
) (
  input  logic            clk_tx_sched,
  input  logic            rst_tx_sched,
  input  logic            enable,
  input  logic            flush,
  output logic            busy,
  output logic [7:0]      frames_sent,
  uart_tx_sched_if.master bus
);

  localparam int unsigned GapW    = (FRAME_GAP < 2) ? 1 : $clog2(FRAME_GAP);
  localparam int unsigned GapLast = (FRAME_GAP == 0) ? 0 : FRAME_GAP - 1;
  localparam logic [LevelWidth-1:0] BatchLevel = LevelWidth'(BATCH_THRESHOLD);

  state_e               state_q, state_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [DataWidth-1:0] data_q;
  logic [7:0]           frames_q;
  logic                 timer_run, timer_expired, trigger, gap_done;

  assign timer_run = (state_q == StIdle) && bus.fifo_tx_status;

  tx_idle_timer #(
    .TIMEOUT (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk     (clk_tx_sched),
    .rst     (rst_tx_sched),
    .run     (timer_run),
    .expired (timer_expired)
  );

  // Coinciding triggers collapse into a single IDLE -> START transition.
  assign trigger = enable && ((bus.fifo_level >= BatchLevel) ||
                              (flush && bus.fifo_tx_status) ||
                              timer_expired);

  // A zero-length gap still spends one cycle in StGap.
  assign gap_done = (gap_q == GapW'(GapLast));
  assign gap_d    = ((state_q == StGap) && !gap_done) ? gap_q + GapW'(1) : '0;

  always_ff @(posedge clk_tx_sched or posedge rst_tx_sched) begin
    if (rst_tx_sched) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_tx_sched or posedge rst_tx_sched) begin
    if (rst_tx_sched) begin
      gap_q    <= '0;
      data_q   <= '0;
      frames_q <= '0;
    end else begin
      gap_q <= gap_d;
      if (state_q == StCapture) begin
        data_q <= bus.fifo_data;
      end
      if ((state_q == StWaitDone) && !bus.uart_busy) begin
        frames_q <= frames_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (trigger) state_d = StStart;
      StStart:    state_d = StFetch;
      StFetch:    state_d = StCapture;
      StCapture:  state_d = StLoad;
      StLoad:     if (!bus.uart_busy) state_d = StWaitAck;
      StWaitAck:  if (bus.uart_busy) state_d = StWaitDone;
      StWaitDone: if (!bus.uart_busy) state_d = StGap;
      StGap: begin
        if (gap_done) begin
          state_d = (enable && bus.fifo_tx_status) ? StFetch : StIdle;
        end
      end
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.start_tx   = (state_q == StStart);
    bus.next_frame = (state_q == StFetch);
    bus.uart_load  = (state_q == StLoad) && !bus.uart_busy;
    bus.uart_data  = data_q;
    busy           = (state_q != StIdle);
    frames_sent    = frames_q;
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural FIFO and UART on the far side.
module tb_uart_tx_sched;
  import uart_tx_sched_pkg::*;

  localparam int unsigned UartLen = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       flush;
  logic       busy;
  logic [7:0] frames_sent;

  always #5 clk = ~clk;

  uart_tx_sched_if bus_if ();

  uart_tx_sched #(
    .BATCH_THRESHOLD (16),
    .IDLE_TIMEOUT    (1000),
    .FRAME_GAP       (2)
  ) dut (
    .clk_tx_sched (clk),
    .rst_tx_sched (rst),
    .enable       (enable),
    .flush        (flush),
    .busy         (busy),
    .frames_sent  (frames_sent),
    .bus          (bus_if)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] loaded[$];
  int         n_start  = 0;
  int         n_next   = 0;
  int         n_load   = 0;
  bit         uart_pend = 1'b0;
  int         uart_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_level();
    bus_if.fifo_level     = 5'(fifo_q.size());
    bus_if.fifo_tx_status = (fifo_q.size() != 0);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    sync_level();
  endtask

  // One clock: sample DUT strobes on the falling edge, then advance the FIFO/UART models.
  task automatic tick();
    logic s, n, l;
    logic [7:0] d;
    int cnt;
    @(negedge clk);
    s = bus_if.start_tx;
    n = bus_if.next_frame;
    l = bus_if.uart_load;
    d = bus_if.uart_data;
    cnt = int'(s) + int'(n) + int'(l);
    check("strobe_excl", 32'(cnt <= 1), 32'd1);
    if (s) n_start++;
    if (uart_pend) begin
      bus_if.uart_busy = 1'b1;
      uart_cnt = UartLen;
      uart_pend = 1'b0;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) bus_if.uart_busy = 1'b0;
    end
    if (l) begin
      n_load++;
      loaded.push_back(d);
      uart_pend = 1'b1;
    end
    if (n) begin
      n_next++;
      if (fifo_q.size() > 0) bus_if.fifo_data = fifo_q.pop_front();
    end
    sync_level();
  endtask

  task automatic wait_start(input int limit, input string tag, output int waited);
    int base;
    base = n_start;
    waited = 0;
    while ((n_start == base) && (waited < limit)) begin
      tick();
      waited++;
    end
    check(tag, 32'(n_start != base), 32'd1);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int waited;
    waited = 0;
    while (busy && (waited < limit)) begin
      tick();
      waited++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_loads(input int target, input int limit, input string tag);
    int waited;
    waited = 0;
    while ((n_load < target) && (waited < limit)) begin
      tick();
      waited++;
    end
    check(tag, 32'(n_load >= target), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] first, input int count);
    logic [7:0] obs;
    check({tag, "_count"}, 32'(loaded.size()), 32'(count));
    for (int i = 0; i < count; i++) begin
      obs = (i < loaded.size()) ? loaded[i] : 8'hxx;
      check(tag, 32'(obs), 32'(8'(first + 8'(i))));
    end
  endtask

  initial begin
    int waited;
    int base_next, base_load, base_start;
    bit max_busy;
    logic [7:0] b_start;

    rst = 1'b1;
    enable = 1'b0;
    flush = 1'b0;
    bus_if.fifo_level = '0;
    bus_if.fifo_tx_status = 1'b0;
    bus_if.fifo_data = '0;
    bus_if.uart_busy = 1'b0;
    tick();
    tick();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_udata", 32'(bus_if.uart_data), 32'd0);
    check("rst_start", 32'(bus_if.start_tx), 32'd0);
    check("rst_next", 32'(bus_if.next_frame), 32'd0);
    check("rst_load", 32'(bus_if.uart_load), 32'd0);
    check("rst_timer", 32'(dut.u_idle_timer.count_q), 32'd0);

    rst = 1'b0;
    enable = 1'b1;
    tick();

    // Flush with nothing queued must not start a burst.
    flush = 1'b1;
    max_busy = 1'b0;
    tick();
    flush = 1'b0;
    if (busy) max_busy = 1'b1;
    repeat (10) begin
      tick();
      if (busy) max_busy = 1'b1;
    end
    check("flush_empty_start", 32'(n_start), 32'd0);
    check("flush_empty_busy", 32'(max_busy), 32'd0);

    // Flush with three bytes queued.
    push(8'h11);
    push(8'h12);
    push(8'h13);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_start_next", 32'(n_start), 32'd1);
    tick();
    check("flush_timer_clr", 32'(dut.u_idle_timer.count_q), 32'd0);
    wait_idle(300, "flush_idle");
    check("flush_frames", 32'(frames_sent), 32'd3);
    check("flush_next", 32'(n_next), 32'd3);
    check_bytes("flush_bytes", 8'h11, 3);

    // Level threshold: 15 bytes wait, the 16th fires the burst.
    loaded.delete();
    for (int i = 0; i < 15; i++) begin
      push(8'(8'h40 + 8'(i)));
      tick();
    end
    check("batch_no_early", 32'(n_start), 32'd1);
    push(8'h4F);
    wait_start(2, "batch_start", waited);
    check("batch_lat", 32'(waited <= 2), 32'd1);
    wait_idle(1000, "batch_idle");
    check("batch_frames", 32'(frames_sent), 32'h13);
    check_bytes("batch_bytes", 8'h40, 16);

    // Partial FIFO forced out by the idle timeout.
    loaded.delete();
    for (int i = 1; i <= 5; i++) push(8'(i));
    wait_start(1100, "tmo_start", waited);
    check("tmo_lat", 32'(waited), 32'd1001);
    check("tmo_timer", 32'(dut.u_idle_timer.count_q), 32'd1000);
    wait_idle(500, "tmo_idle");
    check("tmo_frames", 32'(frames_sent), 32'h18);
    check_bytes("tmo_bytes", 8'h01, 5);

    // Enable dropped during frame 2 of 5.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("en_rst_frames", 32'(frames_sent), 32'd0);
    loaded.delete();
    base_next = n_next;
    base_load = n_load;
    for (int i = 0; i < 5; i++) push(8'(8'hA1 + 8'(i)));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_loads(base_load + 2, 200, "en_load2");
    enable = 1'b0;
    wait_idle(300, "en_idle");
    check("en_frames", 32'(frames_sent), 32'd2);
    check("en_next", 32'(n_next - base_next), 32'd2);
    check("en_state", 32'(dut.state_q), 32'(StIdle));
    base_start = n_start;
    repeat (20) tick();
    check("en_no_third", 32'(n_next - base_next), 32'd2);
    check("en_no_restart", 32'(n_start - base_start), 32'd0);
    check_bytes("en_bytes", 8'hA1, 2);
    fifo_q.delete();
    sync_level();

    // Reset while waiting for the UART to finish frame 1.
    enable = 1'b1;
    loaded.delete();
    base_load = n_load;
    b_start = 8'hB1;
    for (int i = 0; i < 3; i++) push(8'(b_start + 8'(i)));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_loads(base_load + 1, 200, "rst_mid_load1");
    waited = 0;
    while ((dut.state_q != StWaitDone) && (waited < 20)) begin
      tick();
      waited++;
    end
    check("rst_mid_reach", 32'(dut.state_q), 32'(StWaitDone));
    rst = 1'b1;
    #1;
    check("rst_mid_start", 32'(bus_if.start_tx), 32'd0);
    check("rst_mid_next", 32'(bus_if.next_frame), 32'd0);
    check("rst_mid_load", 32'(bus_if.uart_load), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_frames", 32'(frames_sent), 32'd0);
    check("rst_mid_udata", 32'(bus_if.uart_data), 32'd0);
    tick();
    rst = 1'b0;
    base_load = n_load;
    base_start = n_start;
    max_busy = 1'b0;
    repeat (30) begin
      tick();
      if (busy) max_busy = 1'b1;
    end
    check("rst_mid_quiet_load", 32'(n_load - base_load), 32'd0);
    check("rst_mid_quiet_start", 32'(n_start - base_start), 32'd0);
    check("rst_mid_quiet_busy", 32'(max_busy), 32'd0);

    // A fresh trigger drains what the abandoned burst left behind.
    loaded.delete();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("rst_mid_restart", 32'(n_start - base_start), 32'd1);
    wait_idle(300, "rst_mid_idle");
    check("rst_mid_frames2", 32'(frames_sent), 32'd2);
    check_bytes("rst_mid_bytes", 8'hB2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter BATCH_THRESHOLD, default 16, is the FIFO level that triggers a burst.
REQ-002 Parameter IDLE_TIMEOUT, default 1000, is the cycles a partial FIFO may wait before a forced burst.
REQ-003 Parameter FRAME_GAP, default 2, is the idle cycles inserted between consecutive frames.
REQ-004 clk_tx_sched  in  1  single clock; all logic on its rising edge.
REQ-005 rst_tx_sched  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  scheduler enable.
REQ-007 flush  in  1  one-cycle request to transmit partial FIFO contents immediately.
REQ-008 fifo_level  in  5  TX FIFO occupancy, 0..16.
REQ-009 fifo_tx_status  in  1  FIFO non-empty.
REQ-010 fifo_data  in  8  FIFO read data, valid one cycle after next_frame.
REQ-011 uart_busy  in  1  UART transmitter shifting a frame.
REQ-012 start_tx  out  1  one-cycle pulse to the FIFO marking burst start.
REQ-013 next_frame  out  1  one-cycle FIFO pop strobe.
REQ-014 uart_data  out  8  registered byte for the UART.
REQ-015 uart_load  out  1  one-cycle load strobe to the UART.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 frames_sent  out  8  count of completed frames.

Function
REQ-018 States: IDLE, START, FETCH, CAPTURE, LOAD, WAIT_ACK, WAIT_DONE, GAP.
REQ-019 IDLE -> START when enable=1 and any of: fifo_level>=BATCH_THRESHOLD; flush=1 with fifo_tx_status=1; idle timer==IDLE_TIMEOUT.
REQ-020 Idle timer counts in IDLE while fifo_tx_status=1, clears when fifo_tx_status=0 or on leaving IDLE, and saturates at IDLE_TIMEOUT.
REQ-021 Trigger conditions coinciding in one cycle produce exactly one burst.
REQ-022 flush with an empty FIFO is ignored and not remembered.
REQ-023 START: start_tx=1 for one cycle -> FETCH.
REQ-024 FETCH: next_frame=1 for one cycle -> CAPTURE.
REQ-025 CAPTURE: uart_data<=fifo_data -> LOAD.
REQ-026 LOAD: hold until uart_busy=0, then uart_load=1 for one cycle -> WAIT_ACK.
REQ-027 WAIT_ACK: -> WAIT_DONE on uart_busy=1.
REQ-028 WAIT_DONE: on uart_busy=0, frames_sent increments (modulo 256, 255->0) -> GAP.
REQ-029 GAP: after FRAME_GAP cycles, -> FETCH if enable=1 and fifo_tx_status=1, else -> IDLE.
REQ-030 FRAME_GAP=0 passes through GAP in exactly one cycle.
REQ-031 A burst drains the FIFO to empty, irrespective of the level that triggered it.
REQ-032 enable deasserted mid-burst: the current frame completes, then -> IDLE.
REQ-033 Next burst start_tx is asserted no earlier than 1 cycle after returning to IDLE.
REQ-034 At most one of start_tx, next_frame and uart_load is high in any cycle.
REQ-035 uart_data holds its value from CAPTURE until the next CAPTURE.

Reset
REQ-036 While rst_tx_sched=1, asynchronously: state=IDLE, idle timer=0, gap counter=0, start_tx=0, next_frame=0, uart_load=0, busy=0, uart_data=8'h00, frames_sent=8'h00.
REQ-037 Reset mid-burst abandons the frame with no further strobes; FIFO contents are not the scheduler's concern.

Structure
REQ-038 Shared package holds the state enumeration, the FIFO depth constant 16, and the data width constant 8.
REQ-039 One sub-module, tx_idle_timer, implements the saturating idle timer; all else is inline.

Verification
REQ-040 5 bytes written, no flush, IDLE_TIMEOUT=1000 -> start_tx at timer=1000, then 5 uart_load pulses carrying bytes 01..05 in order; frames_sent=5; -> IDLE.
REQ-041 16 bytes written -> start_tx within 2 cycles of fifo_level=16; 16 frames; frames_sent=16.
REQ-042 3 bytes written, flush pulse -> start_tx the next cycle; 3 frames; idle timer cleared.
REQ-043 flush with an empty FIFO -> no start_tx; busy stays 0.
REQ-044 enable dropped during frame 2 of 5 -> frame 2 completes; no third next_frame; state IDLE; frames_sent=2.
REQ-045 rst_tx_sched pulsed while in WAIT_DONE -> all outputs 0 immediately; frames_sent=0; no uart_load after release until a new trigger.
